// File: rtl/stream2wb_pkg.sv
// Shared constants for the byte-stream to Wishbone burst engine.
package stream2wb_pkg;

    // Command opcodes carried in rx byte [7:5]; 3'b111 is decoded as a NOP
    localparam logic [2:0] OP_NOP       = 3'b000;
    localparam logic [2:0] OP_SET_ADDR  = 3'b001;
    localparam logic [2:0] OP_SET_AUX   = 3'b010;
    localparam logic [2:0] OP_WRITE     = 3'b011;
    localparam logic [2:0] OP_WRITE_INC = 3'b100;
    localparam logic [2:0] OP_READ      = 3'b101;
    localparam logic [2:0] OP_READ_INC  = 3'b110;

    // Bit positions inside the status byte
    localparam int ST_BIT_TO  = 0;
    localparam int ST_BIT_SEL = 1;

    // FSM state encoding
    localparam logic [2:0] S_CMD        = 3'd0;
    localparam logic [2:0] S_ARG        = 3'd1;
    localparam logic [2:0] S_WR_COLLECT = 3'd2;
    localparam logic [2:0] S_WB_CYCLE   = 3'd3;
    localparam logic [2:0] S_RD_SEND    = 3'd4;
    localparam logic [2:0] S_STATUS     = 3'd5;

    // Number of top address bits used as slave select (at least one)
    function automatic int calc_sw(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/stream2wb_wbm.sv
// Wishbone master for a single word access: slave decode, ack/timeout
// handling and read-data mux. Held active by start for the whole access.
module stream2wb_wbm
    import stream2wb_pkg::*;
#(
    parameter int WB_N    = 3,
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      wdata,
    output logic               done,
    output logic [DW-1:0]      rdata,
    output logic               err_to,
    output logic               err_sel,
    output logic [WB_N-1:0]    wb_cyc,
    output logic               wb_we,
    output logic [AW-1:0]      wb_addr,
    output logic [DW-1:0]      wb_wdata,
    input  logic [DW*WB_N-1:0] wb_rdata,
    input  logic [WB_N-1:0]    wb_ack
);

    localparam int SW = calc_sw(WB_N);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [SW-1:0] sel;
    logic          sel_ok;
    logic          ack_hit;
    logic          to_hit;
    logic [DW-1:0] rd_mux;
    logic [TW-1:0] to_cnt;

    assign sel      = addr[AW-1 -: SW];
    assign sel_ok   = ({1'b0, sel} < (SW+1)'(WB_N));
    assign wb_we    = start & we;
    assign wb_addr  = addr;
    assign wb_wdata = wdata;

    // One-hot cyc for the addressed slave; only its ack and data are seen
    always_comb begin
        wb_cyc  = '0;
        ack_hit = 1'b0;
        rd_mux  = '0;
        for (int i = 0; i < WB_N; i++) begin
            if (sel == SW'(i)) begin
                wb_cyc[i] = start;
                ack_hit   = wb_ack[i];
                rd_mux    = wb_rdata[i*DW +: DW];
            end
        end
    end

    // An ack arriving on the last allowed cycle wins over the timeout
    assign to_hit  = (TIMEOUT != 0) && start && sel_ok && !ack_hit && (to_cnt == '0);
    assign err_to  = to_hit;
    assign err_sel = start && !sel_ok;
    assign done    = start && (!sel_ok || ack_hit || to_hit);
    assign rdata   = (start && ack_hit) ? rd_mux : '0;

    // Timeout down-counter, reloaded whenever no access is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                to_cnt <= TO_LOAD;
        else if (!start || done)   to_cnt <= TO_LOAD;
        else                       to_cnt <= to_cnt - TW'(1);
    end

endmodule

// File: rtl/stream2wb_burst.sv
// Byte-stream command engine driving up to WB_N Wishbone slaves plus an aux CSR.
//
// state        | meaning
// CMD          | wait for a command byte
// ARG          | shift in SET_ADDR / SET_AUX argument bytes
// WR_COLLECT   | gather one write word, MSB first
// WB_CYCLE     | one Wishbone access in flight
// RD_SEND      | stream the read word out, MSB first
// STATUS       | emit the status byte with tx_last
module stream2wb_burst
    import stream2wb_pkg::*;
#(
    parameter int WB_N    = 3,
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_last,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [DW-1:0]      wb_wdata,
    input  logic [DW*WB_N-1:0] wb_rdata,
    output logic [AW-1:0]      wb_addr,
    output logic               wb_we,
    output logic [WB_N-1:0]    wb_cyc,
    input  logic [WB_N-1:0]    wb_ack,
    output logic [31:0]        aux_csr
);

    localparam int BPW  = DW / 8;
    localparam int ABY  = AW / 8;
    localparam int ARGW = (AW > 32) ? AW : 32;

    logic [2:0]      state;
    logic            run;
    logic [2:0]      op;
    logic            arg_aux;
    logic [4:0]      len_cnt;
    logic [7:0]      byte_cnt;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rshift;
    logic [31:0]     aux;
    logic [ARGW-1:0] arg_sh;
    logic [1:0]      status;

    logic [ARGW+7:0] arg_cat;
    logic [DW+7:0]   w_cat;
    logic [DW+7:0]   r_cat;
    logic            rx_fire;
    logic            tx_fire;
    logic            op_wr;
    logic            op_inc;
    logic            wbm_start;
    logic            wbm_done;
    logic            wbm_err_to;
    logic            wbm_err_sel;
    logic [DW-1:0]   wbm_rdata;

    assign arg_cat   = {arg_sh, rx_data};
    assign w_cat     = {wdata, rx_data};
    assign r_cat     = {rshift, 8'h00};
    assign op_wr     = (op == OP_WRITE) || (op == OP_WRITE_INC);
    assign op_inc    = (op == OP_WRITE_INC) || (op == OP_READ_INC);
    assign wbm_start = (state == S_WB_CYCLE);

    // run keeps rx_ready low while reset is asserted and for one cycle after
    assign rx_ready = run && ((state == S_CMD) || (state == S_ARG) || (state == S_WR_COLLECT));
    assign tx_valid = (state == S_RD_SEND) || (state == S_STATUS);
    assign tx_last  = (state == S_STATUS);
    assign tx_data  = (state == S_STATUS)
                    ? {6'b0, status[ST_BIT_SEL], status[ST_BIT_TO]}
                    : rshift[DW-1 -: 8];
    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign aux_csr  = aux;

    stream2wb_wbm #(
        .WB_N    (WB_N),
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) u_wbm (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wbm_start),
        .we       (op_wr),
        .addr     (addr),
        .wdata    (wdata),
        .done     (wbm_done),
        .rdata    (wbm_rdata),
        .err_to   (wbm_err_to),
        .err_sel  (wbm_err_sel),
        .wb_cyc   (wb_cyc),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_ack   (wb_ack)
    );

    // Command sequencer: decode, argument/payload shifting, burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CMD;
            run      <= 1'b0;
            op       <= OP_NOP;
            arg_aux  <= 1'b0;
            len_cnt  <= '0;
            byte_cnt <= '0;
            addr     <= '0;
            wdata    <= '0;
            rshift   <= '0;
            aux      <= '0;
            arg_sh   <= '0;
            status   <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                S_CMD: if (rx_fire) begin
                    op      <= rx_data[7:5];
                    len_cnt <= rx_data[4:0];
                    case (rx_data[7:5])
                        OP_SET_ADDR: begin
                            arg_aux  <= 1'b0;
                            byte_cnt <= 8'(ABY - 1);
                            state    <= S_ARG;
                        end
                        OP_SET_AUX: begin
                            arg_aux  <= 1'b1;
                            byte_cnt <= 8'd3;
                            state    <= S_ARG;
                        end
                        OP_WRITE, OP_WRITE_INC: begin
                            status   <= '0;
                            byte_cnt <= 8'(BPW - 1);
                            state    <= S_WR_COLLECT;
                        end
                        OP_READ, OP_READ_INC: begin
                            status <= '0;
                            state  <= S_WB_CYCLE;
                        end
                        default: state <= S_CMD;
                    endcase
                end
                S_ARG: if (rx_fire) begin
                    arg_sh <= arg_cat[ARGW-1:0];
                    if (byte_cnt == '0) begin
                        if (arg_aux) aux  <= arg_cat[31:0];
                        else         addr <= arg_cat[AW-1:0];
                        state <= S_CMD;
                    end else begin
                        byte_cnt <= byte_cnt - 8'd1;
                    end
                end
                S_WR_COLLECT: if (rx_fire) begin
                    wdata <= w_cat[DW-1:0];
                    if (byte_cnt == '0) state <= S_WB_CYCLE;
                    else                byte_cnt <= byte_cnt - 8'd1;
                end
                S_WB_CYCLE: if (wbm_done) begin
                    status[ST_BIT_TO]  <= status[ST_BIT_TO]  | wbm_err_to;
                    status[ST_BIT_SEL] <= status[ST_BIT_SEL] | wbm_err_sel;
                    if (op_inc) addr <= addr + AW'(1);
                    byte_cnt <= 8'(BPW - 1);
                    if (op_wr) begin
                        if (len_cnt == '0) begin
                            state <= S_STATUS;
                        end else begin
                            len_cnt <= len_cnt - 5'd1;
                            state   <= S_WR_COLLECT;
                        end
                    end else begin
                        rshift <= wbm_rdata;
                        state  <= S_RD_SEND;
                    end
                end
                S_RD_SEND: if (tx_fire) begin
                    rshift <= r_cat[DW-1:0];
                    if (byte_cnt != '0) begin
                        byte_cnt <= byte_cnt - 8'd1;
                    end else if (len_cnt == '0) begin
                        state <= S_STATUS;
                    end else begin
                        len_cnt <= len_cnt - 5'd1;
                        state   <= S_WB_CYCLE;
                    end
                end
                S_STATUS: if (tx_fire) state <= S_CMD;
                default: state <= S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_stream2wb_burst.sv
// Directed bench for stream2wb_burst with three model slaves:
// slave 0 acks after one cycle and returns addr*0x11111111,
// slave 1 acks after one cycle and returns 0xA5A5A5A5, slave 2 never acks.
module tb_stream2wb_burst;

    localparam int WB_N = 3;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int TO   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic [7:0]          tx_data;
    logic                tx_last;
    logic                tx_valid;
    logic                tx_ready = 1'b0;
    logic [DW-1:0]       wb_wdata;
    logic [DW*WB_N-1:0]  wb_rdata;
    logic [AW-1:0]       wb_addr;
    logic                wb_we;
    logic [WB_N-1:0]     wb_cyc;
    logic [WB_N-1:0]     wb_ack;
    logic [31:0]         aux_csr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream2wb_burst #(
        .WB_N    (WB_N),
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_addr  (wb_addr),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack),
        .aux_csr  (aux_csr)
    );

    // Slave models
    logic [WB_N-1:0] ack_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_r <= '0;
        else begin
            ack_r[0] <= wb_cyc[0] & ~ack_r[0];
            ack_r[1] <= wb_cyc[1] & ~ack_r[1];
            ack_r[2] <= 1'b0;
        end
    end
    assign wb_ack   = ack_r;
    assign wb_rdata = {32'h0, 32'hA5A5A5A5, 32'(wb_addr) * 32'h11111111};

    // Bus monitor: counts cyc-high cycles and records the last acked access
    int              cyc_cnt = 0;
    int              ack_cnt = 0;
    logic [WB_N-1:0] m_cyc = '0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic            m_we = 1'b0;
    always @(posedge clk) begin
        if (|wb_cyc) begin
            cyc_cnt++;
            if (|(wb_cyc & wb_ack)) begin
                ack_cnt++;
                m_cyc   = wb_cyc;
                m_addr  = wb_addr;
                m_wdata = wb_wdata;
                m_we    = wb_we;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic recv_chk(input string tag, input logic [7:0] exp, input logic exp_last);
        int n = 0;
        @(negedge clk);
        tx_ready = 1'b1;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {55'd0, tx_valid, tx_last, tx_data}, {55'd0, 1'b1, exp_last, exp});
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    initial begin
        int   c0;
        int   a0;
        int   n;
        logic hold_bad;
        logic [7:0] d0;
        logic [7:0] rd_exp [4];

        // Reset state
        #1;
        chk("rst_cyc",   wb_cyc,   0);
        chk("rst_we",    wb_we,    0);
        chk("rst_addr",  wb_addr,  0);
        chk("rst_wdata", wb_wdata, 0);
        chk("rst_aux",   aux_csr,  0);
        chk("rst_tx",    {tx_valid, tx_last, tx_data}, 0);
        chk("rst_rxrdy", rx_ready, 0);
        #20 rst_n = 1'b1;

        // Single WRITE_INC to slave 1
        send_byte(8'h20); send_byte(8'h40); send_byte(8'h10);
        a0 = ack_cnt;
        send_byte(8'h80);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        recv_chk("wr_status", 8'h00, 1'b1);
        chk("wr_acks",  ack_cnt - a0, 1);
        chk("wr_cyc",   m_cyc,   3'b010);
        chk("wr_addr",  m_addr,  16'h4010);
        chk("wr_wdata", m_wdata, 32'hDEADBEEF);
        chk("wr_we",    m_we,    1);
        chk("wr_inc",   wb_addr, 16'h4011);

        // READ_INC burst of 4 words from slave 0
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hC3);
        rd_exp[0] = 8'h55; rd_exp[1] = 8'h66; rd_exp[2] = 8'h77; rd_exp[3] = 8'h88;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                recv_chk($sformatf("rd_w%0d_b%0d", w, b), rd_exp[w], 1'b0);
        recv_chk("rd_status", 8'h00, 1'b1);
        chk("rd_final_addr", wb_addr, 16'h0009);

        // Bad slave select
        send_byte(8'h20); send_byte(8'hC0); send_byte(8'h00);
        c0 = cyc_cnt;
        send_byte(8'h60);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        recv_chk("badsel_status", 8'h02, 1'b1);
        chk("badsel_nocyc", cyc_cnt - c0, 0);

        // Timeout on slave 2
        send_byte(8'h20); send_byte(8'h80); send_byte(8'h00);
        c0 = cyc_cnt;
        send_byte(8'hA0);
        for (int b = 0; b < 4; b++) recv_chk($sformatf("to_b%0d", b), 8'h00, 1'b0);
        recv_chk("to_status", 8'h01, 1'b1);
        chk("to_cyc_cycles", cyc_cnt - c0, TO);

        // SET_AUX, then a READ held off by tx_ready
        send_byte(8'h40); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        @(negedge clk);
        chk("aux_val",  aux_csr,  32'h12345678);
        chk("aux_notx", tx_valid, 0);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hA0);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        d0 = tx_data;
        hold_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== d0 || rx_ready !== 1'b0) hold_bad = 1'b1;
        end
        chk("hold_first", d0, 8'h22);
        chk("hold_stable", hold_bad, 0);
        for (int b = 0; b < 4; b++) recv_chk($sformatf("hold_b%0d", b), 8'h22, 1'b0);
        recv_chk("hold_status", 8'h00, 1'b1);

        // Asynchronous reset mid WRITE_INC
        send_byte(8'h20); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h80); send_byte(8'hDE); send_byte(8'hAD);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc",   wb_cyc,   0);
        chk("arst_we",    wb_we,    0);
        chk("arst_addr",  wb_addr,  0);
        chk("arst_wdata", wb_wdata, 0);
        chk("arst_aux",   aux_csr,  0);
        chk("arst_tx",    {tx_valid, tx_last, tx_data}, 0);
        chk("arst_rxrdy", rx_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h20); send_byte(8'h40); send_byte(8'h20);
        a0 = ack_cnt;
        send_byte(8'h60);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        recv_chk("post_rst_status", 8'h00, 1'b1);
        chk("post_rst_acks",  ack_cnt - a0, 1);
        chk("post_rst_cyc",   m_cyc,   3'b010);
        chk("post_rst_addr",  m_addr,  16'h4020);
        chk("post_rst_wdata", m_wdata, 32'h11223344);
        chk("post_rst_fixed", wb_addr, 16'h4020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
